// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: soft-reset request in, per-channel resets and status out.
interface reset_sequencer_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 SOFT_RST_REQ;
  logic [NUM_CH-1:0]    CH_RST;
  logic [NUM_CH-1:0]    CH_RSTN;
  logic                 SEQ_DONE;
  logic                 SOFT_RST_BUSY;
  logic [CNT_WIDTH-1:0] CYCLE_COUNT;
  logic                 TIMEOUT;

  modport master (
    input  SOFT_RST_REQ,
    output CH_RST, CH_RSTN, SEQ_DONE, SOFT_RST_BUSY, CYCLE_COUNT, TIMEOUT
  );

  modport slave (
    output SOFT_RST_REQ,
    input  CH_RST, CH_RSTN, SEQ_DONE, SOFT_RST_BUSY, CYCLE_COUNT, TIMEOUT
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staggered release of NUM_CH reset domains with soft-reset replay,
// a saturating cycle counter and a sticky timeout flag.
module reset_sequencer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned BASE_DELAY   = 4,
  parameter int unsigned DELAY_STEP   = 4,
  parameter int unsigned SOFT_RST_LEN = 8,
  parameter int unsigned MAX_CYCLES   = 1000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic USER_CLK,
  input logic USER_RST,
  reset_sequencer_if.master bus
);

  typedef enum logic [1:0] {HOLD, RELEASE, RUN, SOFT} state_e;

  localparam logic [CNT_WIDTH-1:0] FIRST_REL = CNT_WIDTH'(BASE_DELAY);
  localparam logic [CNT_WIDTH-1:0] LAST_REL  = CNT_WIDTH'(BASE_DELAY + (NUM_CH - 1) * DELAY_STEP);
  localparam logic [CNT_WIDTH-1:0] SOFT_END  = CNT_WIDTH'(SOFT_RST_LEN);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT   = CNT_WIDTH'(MAX_CYCLES);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] t_q, t_d;
  logic [CNT_WIDTH-1:0] s_q, s_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]    ch_rst_q, ch_rst_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    s_d      = s_q;
    ch_rst_d = ch_rst_q;
    done_d   = done_q;
    busy_d   = busy_q;
    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    tmo_d    = tmo_q | ((MAX_CYCLES != 0) && (cnt_d == MAX_CNT));

    case (state_q)
      HOLD, RELEASE: begin
        t_d = t_q + CNT_WIDTH'(1);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (t_d == CNT_WIDTH'(BASE_DELAY + k * DELAY_STEP)) ch_rst_d[k] = 1'b0;
        end
        // Last-release test first so a single channel goes straight to RUN.
        if (t_d == LAST_REL) begin
          state_d = RUN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (t_d == FIRST_REL) begin
          state_d = RELEASE;
        end
      end
      RUN: begin
        if (bus.SOFT_RST_REQ) begin
          state_d  = SOFT;
          ch_rst_d = '1;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          s_d      = '0;
        end
      end
      SOFT: begin
        s_d = s_q + CNT_WIDTH'(1);
        if (s_d == SOFT_END) begin
          state_d = HOLD;
          t_d     = '0;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge USER_CLK) begin
    if (USER_RST) begin
      state_q  <= HOLD;
      t_q      <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      ch_rst_q <= '1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      ch_rst_q <= ch_rst_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.CH_RST        = ch_rst_q;
  assign bus.CH_RSTN       = ~ch_rst_q;
  assign bus.SEQ_DONE      = done_q;
  assign bus.SOFT_RST_BUSY = busy_q;
  assign bus.CYCLE_COUNT   = cnt_q;
  assign bus.TIMEOUT       = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three parameter sets driven in lockstep and
// compared every cycle against a time-based model of the release schedule.
module tb_reset_sequencer;

  logic clk;
  logic rst;
  logic req;

  int errors = 0;
  int checks = 0;

  // Per-instance configuration: nominal+timeout50, odd timing with no timeout, minimal edge case.
  int nch  [3] = '{4, 3, 1};
  int base [3] = '{4, 2, 1};
  int stp  [3] = '{4, 3, 4};
  int slen [3] = '{8, 5, 8};
  int maxc [3] = '{50, 0, 0};
  int wid  [3] = '{16, 16, 4};

  typedef struct {
    int elapsed;
    int origin;
    int soft_end;
    bit insoft;
    bit busy;
  } mdl_t;
  mdl_t m [3];

  reset_sequencer_if #(.NUM_CH(4), .CNT_WIDTH(16)) if0 ();
  reset_sequencer_if #(.NUM_CH(3), .CNT_WIDTH(16)) if1 ();
  reset_sequencer_if #(.NUM_CH(1), .CNT_WIDTH(4))  if2 ();

  assign if0.SOFT_RST_REQ = req;
  assign if1.SOFT_RST_REQ = req;
  assign if2.SOFT_RST_REQ = req;

  reset_sequencer #(.NUM_CH(4), .BASE_DELAY(4), .DELAY_STEP(4), .SOFT_RST_LEN(8),
                    .MAX_CYCLES(50), .CNT_WIDTH(16))
    u0 (.USER_CLK(clk), .USER_RST(rst), .bus(if0));
  reset_sequencer #(.NUM_CH(3), .BASE_DELAY(2), .DELAY_STEP(3), .SOFT_RST_LEN(5),
                    .MAX_CYCLES(0), .CNT_WIDTH(16))
    u1 (.USER_CLK(clk), .USER_RST(rst), .bus(if1));
  reset_sequencer #(.NUM_CH(1), .BASE_DELAY(1), .DELAY_STEP(4), .SOFT_RST_LEN(8),
                    .MAX_CYCLES(0), .CNT_WIDTH(4))
    u2 (.USER_CLK(clk), .USER_RST(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: elapsed edges since reset; channel k is released once
  // BASE + k*STEP edges have passed since the current sequence origin.
  task automatic model_step(input int i, input logic r, input logic q);
    bit running;
    if (r) begin
      m[i].elapsed = 0;
      m[i].origin = 0;
      m[i].soft_end = 0;
      m[i].insoft = 0;
      m[i].busy = 0;
    end else begin
      running = !m[i].insoft &&
                (m[i].elapsed - m[i].origin >= base[i] + (nch[i] - 1) * stp[i]);
      m[i].elapsed++;
      if (m[i].insoft && m[i].elapsed == m[i].soft_end) begin
        m[i].insoft = 0;
        m[i].origin = m[i].elapsed;
      end else if (running && q) begin
        m[i].insoft = 1;
        m[i].busy = 1;
        m[i].soft_end = m[i].elapsed + slen[i];
      end
    end
  endtask

  task automatic check_dut(input int i, input logic [31:0] ch, input logic [31:0] chn,
                           input logic [31:0] cnt, input logic done, input logic busy,
                           input logic tmo);
    int t, last, maxcnt, ecnt;
    logic [31:0] ech, mask;
    logic edone, ebusy, etmo;
    t      = m[i].elapsed - m[i].origin;
    last   = base[i] + (nch[i] - 1) * stp[i];
    maxcnt = (1 << wid[i]) - 1;
    mask   = 32'((64'd1 << nch[i]) - 1);
    ech    = '0;
    for (int k = 0; k < nch[i]; k++)
      if (m[i].insoft || t < base[i] + k * stp[i]) ech[k] = 1'b1;
    edone = !m[i].insoft && (t >= last);
    ebusy = m[i].insoft || (m[i].busy && t < last);
    ecnt  = (m[i].elapsed > maxcnt) ? maxcnt : m[i].elapsed;
    etmo  = (maxc[i] > 0) && (m[i].elapsed >= maxc[i]);
    chk($sformatf("u%0d.CH_RST@%0d", i, m[i].elapsed), ch, ech);
    chk($sformatf("u%0d.CH_RSTN@%0d", i, m[i].elapsed), chn, ~ech & mask);
    chk($sformatf("u%0d.SEQ_DONE@%0d", i, m[i].elapsed), 32'(done), 32'(edone));
    chk($sformatf("u%0d.BUSY@%0d", i, m[i].elapsed), 32'(busy), 32'(ebusy));
    chk($sformatf("u%0d.COUNT@%0d", i, m[i].elapsed), cnt, 32'(ecnt));
    chk($sformatf("u%0d.TIMEOUT@%0d", i, m[i].elapsed), 32'(tmo), 32'(etmo));
  endtask

  task automatic cyc(input logic r, input logic q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, r, q);
    #1;
    check_dut(0, 32'(if0.CH_RST), 32'(if0.CH_RSTN), 32'(if0.CYCLE_COUNT),
              if0.SEQ_DONE, if0.SOFT_RST_BUSY, if0.TIMEOUT);
    check_dut(1, 32'(if1.CH_RST), 32'(if1.CH_RSTN), 32'(if1.CYCLE_COUNT),
              if1.SEQ_DONE, if1.SOFT_RST_BUSY, if1.TIMEOUT);
    check_dut(2, 32'(if2.CH_RST), 32'(if2.CH_RSTN), 32'(if2.CYCLE_COUNT),
              if2.SEQ_DONE, if2.SOFT_RST_BUSY, if2.TIMEOUT);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;

    // Power-on: reset for 3 edges, then staggered release.
    repeat (3) cyc(1'b1, 1'b0);
    chk("reset.CH_RST", 32'(if0.CH_RST), 32'hF);
    repeat (4) cyc(1'b0, 1'b0);
    chk("pwr.CH_RST@4", 32'(if0.CH_RST), 32'hE);
    chk("edge.CH_RST@4", 32'(if2.CH_RST), 32'h0);
    repeat (12) cyc(1'b0, 1'b0);
    chk("pwr.CH_RST@16", 32'(if0.CH_RST), 32'h0);
    chk("pwr.DONE@16", 32'(if0.SEQ_DONE), 32'h1);
    chk("edge.COUNT@16", 32'(if2.CYCLE_COUNT), 32'hF);

    // Soft reset pulse while count 20 is visible.
    repeat (4) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("soft.CH_RST@21", 32'(if0.CH_RST), 32'hF);
    chk("soft.BUSY@21", 32'(if0.SOFT_RST_BUSY), 32'h1);
    repeat (24) cyc(1'b0, 1'b0);
    chk("soft.DONE@45", 32'(if0.SEQ_DONE), 32'h1);
    chk("soft.BUSY@45", 32'(if0.SOFT_RST_BUSY), 32'h0);
    repeat (5) cyc(1'b0, 1'b0);
    chk("tmo@50", 32'(if0.TIMEOUT), 32'h1);

    // Requests during HOLD/RELEASE are ignored.
    cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    repeat (6) cyc(1'b0, 1'b1);
    repeat (8) cyc(1'b0, 1'b0);
    chk("ign.DONE@19", 32'(if0.SEQ_DONE), 32'h1);

    // Reset mid-sequence while count 10 is visible.
    cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("mid.CH_RST", 32'(if0.CH_RST), 32'hF);
    repeat (20) cyc(1'b0, 1'b0);

    // Level request held high: re-triggers each time RUN is reached.
    repeat (60) cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);

    // Long run without reset: timeout stays set, counters saturate where narrow.
    cyc(1'b1, 1'b0);
    for (int n = 0; n < 200; n++) cyc(1'b0, ($urandom_range(0, 15) == 0));
    chk("long.TIMEOUT@200", 32'(if0.TIMEOUT), 32'h1);
    chk("long.COUNT@200", 32'(if0.CYCLE_COUNT), 32'd200);
    chk("long.u1.TIMEOUT", 32'(if1.TIMEOUT), 32'h0);

    // Random requests with occasional resets.
    for (int n = 0; n < 400; n++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the testbench clock/reset wizard.
- Runs on one clock. Releases NUM_CH reset domains in a staggered order and can re-run that order on a soft-reset request.
- Keeps a free-running cycle count and raises a sticky TIMEOUT flag that benches use to end the simulation.
- Synthesisable. Sits between the top-level reset and the per-block resets in benches and in the core wrapper.

Parameters:
- NUM_CH, 4, number of reset channels (>=1)
- BASE_DELAY, 4, phase cycles before channel 0 releases (>=1)
- DELAY_STEP, 4, cycles between successive channel releases (>=1)
- SOFT_RST_LEN, 8, cycles all channels are held during a soft reset (>=1)
- MAX_CYCLES, 1000, CYCLE_COUNT value at which TIMEOUT sets; 0 disables TIMEOUT
- CNT_WIDTH, 16, width of the counters; BASE_DELAY+(NUM_CH-1)*DELAY_STEP and MAX_CYCLES must each be < 2^CNT_WIDTH

Ports:
- USER_CLK  input  1  clock
- USER_RST  input  1  synchronous, active-high reset
- SOFT_RST_REQ  input  1  single-cycle or level soft-reset request
- CH_RST  output  NUM_CH  per-channel active-high reset
- CH_RSTN  output  NUM_CH  bitwise inverse of CH_RST
- SEQ_DONE  output  1  high when all channels are released
- SOFT_RST_BUSY  output  1  soft-reset sequence in progress
- CYCLE_COUNT  output  CNT_WIDTH  cycles since USER_RST was released, saturating
- TIMEOUT  output  1  sticky; CYCLE_COUNT has reached MAX_CYCLES

Behaviour:
- Reset, on a USER_CLK edge with USER_RST=1:
  - Outputs: CH_RST all 1, CH_RSTN all 0, SEQ_DONE=0, SOFT_RST_BUSY=0, CYCLE_COUNT=0, TIMEOUT=0.
  - Internals: state=HOLD, phase timer T=0, soft counter S=0.
  - USER_RST overrides everything, including a sequence that is mid-flight.
- All outputs are registered. CH_RSTN is the combinational inverse of the CH_RST register.
- CYCLE_COUNT:
  - Increments by 1 on every edge with USER_RST=0 and saturates at 2^CNT_WIDTH-1.
  - Unaffected by soft reset.
- TIMEOUT:
  - Sets on the edge where CYCLE_COUNT becomes MAX_CYCLES (MAX_CYCLES>0).
  - Stays high until USER_RST.
- States: HOLD, RELEASE, RUN, SOFT.
- HOLD / RELEASE:
  - T increments each edge.
  - CH_RST[k] clears on the edge where T becomes BASE_DELAY + k*DELAY_STEP; release order is ascending k.
  - HOLD moves to RELEASE on channel 0's release edge.
  - RELEASE moves to RUN on the edge that releases channel NUM_CH-1.
  - SEQ_DONE goes to 1 on that same edge; SOFT_RST_BUSY goes to 0 on that same edge.
  - With NUM_CH=1, HOLD goes directly to RUN.
- RUN:
  - A SOFT_RST_REQ sampled high moves the block to SOFT.
  - On that edge: CH_RST all 1, SEQ_DONE=0, SOFT_RST_BUSY=1, S=0.
- SOFT:
  - S increments each edge.
  - On the edge where S becomes SOFT_RST_LEN, go to HOLD with T=0; SOFT_RST_BUSY stays 1.
- SOFT_RST_REQ outside RUN is ignored, not queued.
- A level request held high re-triggers only when the block returns to RUN.
- TIMEOUT does not stop the sequencer.

Test Plan (defaults unless noted):
- Power-on: USER_RST high 3 edges then low.
  - CYCLE_COUNT becomes 1..; CH_RST goes 1111 -> 1110 @count4 -> 1100 @8 -> 1000 @12 -> 0000 @16.
  - SEQ_DONE=1 from count 16; CH_RSTN is always ~CH_RST.
- Soft reset: SOFT_RST_REQ pulsed while count 20 is visible.
  - From count 21: CH_RST=1111, SEQ_DONE=0, BUSY=1.
  - Enters HOLD @29; releases @33, 37, 41, 45; SEQ_DONE=1 and BUSY=0 @45.
- Ignored request: SOFT_RST_REQ high during counts 5..10 (in HOLD/RELEASE), then low.
  - Release timing is identical to power-on; no SOFT entry.
- Timeout: MAX_CYCLES=50.
  - TIMEOUT=0 at count 49, 1 at count 50, still 1 at count 200.
  - MAX_CYCLES=0 -> TIMEOUT stays 0.
- Reset mid-sequence: USER_RST high for 1 edge while count 10 is visible (CH_RST=1100).
  - Outputs return to reset values; the full sequence restarts with channel 0 released 4 cycles after release.
- Saturation and edge parameters: CNT_WIDTH=4, MAX_CYCLES=0, NUM_CH=1, BASE_DELAY=1.
  - CH_RST clears @count1; SEQ_DONE=1 @1.
  - CYCLE_COUNT stops at 15.
